// File: rtl/stream_credit_converge.sv
// Merges per-input-port freespace packets and credit-gated output-port FIFO
// traffic onto one registered stream, at most one grant per cycle.

module stream_credit_lane #(
  parameter int CREDIT_BITS        = 8,
  parameter int INIT_CREDIT        = 128,
  parameter int CREDIT_RETURN_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   take_i,
  input  logic                   ret_i,
  output logic [CREDIT_BITS-1:0] credit_o,
  output logic                   nonzero_o
);
  logic [CREDIT_BITS-1:0] credit_q, credit_d;
  logic [32:0]            sum;

  // Take is qualified by nonzero so the counter cannot wrap below zero.
  always_comb begin
    sum = 33'(credit_q)
        + (ret_i ? 33'(CREDIT_RETURN_SIZE) : 33'd0)
        - ((take_i && credit_q != '0) ? 33'd1 : 33'd0);
    credit_d = (sum > 33'(INIT_CREDIT)) ? CREDIT_BITS'(INIT_CREDIT) : sum[CREDIT_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= CREDIT_BITS'(INIT_CREDIT);
    else       credit_q <= credit_d;
  end

  assign credit_o  = credit_q;
  assign nonzero_o = (credit_q != '0);
endmodule

module stream_credit_converge #(
  parameter int PACKET_BITS        = 97,
  parameter int NUM_IN_PORTS       = 7,
  parameter int NUM_OUT_PORTS      = 7,
  parameter int CREDIT_BITS        = 8,
  parameter int INIT_CREDIT        = 128,
  parameter int CREDIT_RETURN_SIZE = 64,
  parameter int CNT_BITS           = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 resend,
  input  logic                                 is_done,
  input  logic [NUM_IN_PORTS-1:0]              freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
  output logic [NUM_IN_PORTS-1:0]              fs_ack,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
  output logic [NUM_OUT_PORTS-1:0]             rd_en_sel,
  input  logic [NUM_OUT_PORTS-1:0]             credit_return,
  output logic [PACKET_BITS-1:0]               stream_out,
  output logic [CREDIT_BITS*NUM_OUT_PORTS-1:0] credit_out,
  output logic [CNT_BITS-1:0]                  stall_cnt
);
  localparam int IP_W = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
  localparam int OP_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [IP_W-1:0]        fs_ptr_q, fs_ptr_d;
  logic [OP_W-1:0]        out_ptr_q, out_ptr_d;
  logic                   done_q;
  logic [CNT_BITS-1:0]    stall_q;
  logic [PACKET_BITS-1:0] stream_q, grant_pkt;

  logic [NUM_IN_PORTS-1:0]                   fs_grant;
  logic [NUM_OUT_PORTS-1:0]                  out_grant, eligible, has_credit;
  logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0] credit;
  logic                                      stall_inc;
  int                                        fs_sel, fs_dist, out_sel, out_dist, d;

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_lane
    stream_credit_lane #(
      .CREDIT_BITS(CREDIT_BITS), .INIT_CREDIT(INIT_CREDIT),
      .CREDIT_RETURN_SIZE(CREDIT_RETURN_SIZE)
    ) u_lane (
      .clk(clk), .reset(reset), .take_i(out_grant[j]), .ret_i(credit_return[j]),
      .credit_o(credit[j]), .nonzero_o(has_credit[j])
    );
  end

  assign eligible = ~empty & has_credit;

  // Round-robin as "smallest rotational distance from the pointer" keeps all
  // vector indexing on constant loop indices.
  always_comb begin
    fs_grant  = '0;
    out_grant = '0;
    grant_pkt = '0;
    fs_ptr_d  = fs_ptr_q;
    out_ptr_d = out_ptr_q;
    fs_sel    = -1;
    out_sel   = -1;
    fs_dist   = NUM_IN_PORTS;
    out_dist  = NUM_OUT_PORTS;
    d         = 0;
    if (!reset && !resend) begin
      if (|freespace_update) begin
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
          d = (i >= int'(fs_ptr_q)) ? i - int'(fs_ptr_q) : i + NUM_IN_PORTS - int'(fs_ptr_q);
          if (freespace_update[i] && d < fs_dist) begin
            fs_dist = d;
            fs_sel  = i;
          end
        end
      end else if (!done_q && !is_done) begin
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
          d = (j >= int'(out_ptr_q)) ? j - int'(out_ptr_q) : j + NUM_OUT_PORTS - int'(out_ptr_q);
          if (eligible[j] && d < out_dist) begin
            out_dist = d;
            out_sel  = j;
          end
        end
      end
    end
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (fs_sel == i) begin
        fs_grant[i] = 1'b1;
        grant_pkt   = packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
        fs_ptr_d    = (i == NUM_IN_PORTS-1) ? '0 : IP_W'(i + 1);
      end
    end
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      if (out_sel == j) begin
        out_grant[j] = 1'b1;
        grant_pkt    = packet_from_output_ports[j*PACKET_BITS +: PACKET_BITS];
        out_ptr_d    = (j == NUM_OUT_PORTS-1) ? '0 : OP_W'(j + 1);
      end
    end
  end

  // Starved: traffic is waiting but every non-empty port is out of credit.
  assign stall_inc = !resend && (freespace_update == '0) && !done_q && !is_done &&
                     (empty != '1) && ((~empty & has_credit) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stream_q  <= '0;
      fs_ptr_q  <= '0;
      out_ptr_q <= '0;
      done_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      done_q <= done_q | is_done;
      if (!resend) begin
        stream_q  <= grant_pkt;
        fs_ptr_q  <= fs_ptr_d;
        out_ptr_q <= out_ptr_d;
      end
      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign fs_ack     = fs_grant;
  assign rd_en_sel  = out_grant;
  assign stream_out = stream_q;
  assign credit_out = credit;
  assign stall_cnt  = stall_q;
endmodule

// File: tb/tb_stream_credit_converge.sv
// Directed vectors plus randomized traffic checked against a cycle-level
// behavioural model of the converge rules.

module tb_stream_credit_converge;
  localparam int PB = 97, NI = 7, NO = 7, CB = 8, INIT = 128, CRS = 64, CW = 32;
  localparam longint MAXST = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, resend, is_done;
  logic [NI-1:0]    fsu, fs_ack;
  logic [PB*NI-1:0] pin;
  logic [NO-1:0]    empty, rd_en_sel, cret;
  logic [PB*NO-1:0] pout;
  logic [PB-1:0]    stream_out;
  logic [CB*NO-1:0] credit_out;
  logic [CW-1:0]    stall_cnt;

  stream_credit_converge dut (
    .clk(clk), .reset(reset), .resend(resend), .is_done(is_done),
    .freespace_update(fsu), .packet_from_input_ports(pin), .fs_ack(fs_ack),
    .empty(empty), .packet_from_output_ports(pout), .rd_en_sel(rd_en_sel),
    .credit_return(cret), .stream_out(stream_out), .credit_out(credit_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else n_pass++;
  endtask

  // Model state (current / next)
  int m_cr[NO], n_cr[NO];
  int m_fsp, m_outp, n_fsp, n_outp;
  bit m_done, n_done;
  longint m_stall, n_stall;
  logic [PB-1:0] m_stream, n_stream;

  task automatic model_reset();
    for (int j = 0; j < NO; j++) m_cr[j] = INIT;
    m_fsp = 0; m_outp = 0; m_done = 0; m_stall = 0; m_stream = '0;
  endtask

  task automatic predict_and_check();
    logic [NI-1:0] efs;
    logic [NO-1:0] erd;
    logic [PB-1:0] epkt;
    logic [CB*NO-1:0] ecr;
    bit all_zero;
    int c;
    efs = '0; erd = '0; epkt = '0;
    for (int j = 0; j < NO; j++) ecr[j*CB +: CB] = CB'(m_cr[j]);
    chk("stream_out", stream_out, m_stream);
    chk("credit_out", credit_out, ecr);
    chk("stall_cnt", stall_cnt, CW'(m_stall));
    n_fsp = m_fsp; n_outp = m_outp;
    if (!reset && !resend) begin
      if (fsu != '0) begin
        for (int k = 0; k < NI; k++) begin
          int i = (m_fsp + k) % NI;
          if (fsu[i]) begin efs[i] = 1'b1; epkt = pin[i*PB +: PB]; n_fsp = (i + 1) % NI; break; end
        end
      end else if (!m_done && !is_done) begin
        for (int k = 0; k < NO; k++) begin
          int j = (m_outp + k) % NO;
          if (!empty[j] && m_cr[j] > 0) begin
            erd[j] = 1'b1; epkt = pout[j*PB +: PB]; n_outp = (j + 1) % NO; break;
          end
        end
      end
    end
    chk("fs_ack", fs_ack, efs);
    chk("rd_en_sel", rd_en_sel, erd);
    if (reset) begin
      for (int j = 0; j < NO; j++) n_cr[j] = INIT;
      n_fsp = 0; n_outp = 0; n_done = 0; n_stall = 0; n_stream = '0;
    end else begin
      for (int j = 0; j < NO; j++) begin
        c = m_cr[j] - (erd[j] ? 1 : 0) + (cret[j] ? CRS : 0);
        n_cr[j] = (c > INIT) ? INIT : c;
      end
      n_stream = resend ? m_stream : epkt;
      n_done = m_done || is_done;
      all_zero = 1;
      for (int j = 0; j < NO; j++) if (!empty[j] && m_cr[j] != 0) all_zero = 0;
      n_stall = (!resend && fsu == '0 && !m_done && !is_done && empty != '1 && all_zero
                 && m_stall < MAXST) ? m_stall + 1 : m_stall;
    end
  endtask

  task automatic step_a(); @(negedge clk); predict_and_check(); endtask

  task automatic step_b();
    @(posedge clk); #1;
    m_cr = n_cr; m_fsp = n_fsp; m_outp = n_outp; m_done = n_done;
    m_stall = n_stall; m_stream = n_stream;
  endtask

  task automatic set_in(input logic [NI-1:0] f, input logic [NO-1:0] e,
                        input logic rs, input logic dn, input logic [NO-1:0] cr);
    fsu = f; empty = e; resend = rs; is_done = dn; cret = cr;
  endtask

  task automatic set_pkts(input bit rnd);
    for (int i = 0; i < NI; i++)
      pin[i*PB +: PB] = rnd ? {1'b1, $urandom, $urandom, $urandom} : {1'b1, 32'h1000_0000 + i, 64'(i)};
    for (int j = 0; j < NO; j++)
      pout[j*PB +: PB] = rnd ? {1'b1, $urandom, $urandom, $urandom} : {1'b1, 32'h2000_0000 + j, 64'(j)};
  endtask

  task automatic do_reset();
    reset = 1'b1; step_a(); step_b(); reset = 1'b0;
  endtask

  typedef struct {
    logic [NI-1:0] fsu;
    logic [NO-1:0] empty;
    logic          resend;
    logic [NI-1:0] exp_fs;
    logic [NO-1:0] exp_rd;
  } vec_t;
  vec_t tbl[10];

  logic [NO-1:0] one_o;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    one_o = 1;
    tbl[0] = '{7'b0000001, 7'b0000000, 1'b0, 7'b0000001, 7'b0000000};
    tbl[1] = '{7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 7'b0000001};
    tbl[2] = '{7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 7'b0000010};
    tbl[3] = '{7'b0000110, 7'b0000000, 1'b0, 7'b0000010, 7'b0000000};
    tbl[4] = '{7'b0000110, 7'b0000000, 1'b0, 7'b0000100, 7'b0000000};
    tbl[5] = '{7'b0000010, 7'b0000000, 1'b0, 7'b0000010, 7'b0000000};
    tbl[6] = '{7'b0000000, 7'b1111011, 1'b0, 7'b0000000, 7'b0000100};
    tbl[7] = '{7'b0000000, 7'b1111110, 1'b0, 7'b0000000, 7'b0000001};
    tbl[8] = '{7'b1111111, 7'b0000000, 1'b1, 7'b0000000, 7'b0000000};
    tbl[9] = '{7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 7'b0000010};

    set_pkts(0);
    set_in('0, '1, 0, 0, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; model_reset();
    chk("reset_stream", stream_out, '0);
    chk("reset_credit", credit_out, {NO{8'd128}});
    chk("reset_stall", stall_cnt, '0);

    // Grants suppressed while reset is held, even with every request up
    set_in('1, '0, 0, 0, '0);
    step_a();
    chk("rst_fs_ack", fs_ack, '0);
    chk("rst_rd_en", rd_en_sel, '0);
    step_b();
    reset = 1'b0;

    // Priority / round-robin / resend vectors
    for (int r = 0; r < 10; r++) begin
      set_in(tbl[r].fsu, tbl[r].empty, tbl[r].resend, 0, '0);
      step_a();
      chk($sformatf("tbl%0d_fs", r), fs_ack, tbl[r].exp_fs);
      chk($sformatf("tbl%0d_rd", r), rd_en_sel, tbl[r].exp_rd);
      step_b();
      if (r == 0) chk("prio_stream", stream_out, pin[0 +: PB]);
    end

    // Output round-robin over all ports twice
    do_reset();
    set_in('0, '0, 0, 0, '0);
    for (int c = 0; c < 14; c++) begin
      step_a(); chk("rr_grant", rd_en_sel, one_o << (c % NO)); step_b();
    end
    chk("rr_credit", credit_out, {NO{8'd126}});

    // Resend freeze, then resume at out_ptr=3
    for (int c = 0; c < 3; c++) begin step_a(); step_b(); end
    set_in('1, '0, 1, 0, '0);
    for (int c = 0; c < 3; c++) begin
      step_a();
      chk("resend_fs", fs_ack, '0);
      chk("resend_rd", rd_en_sel, '0);
      step_b();
      chk("resend_stream", stream_out, pout[2*PB +: PB]);
      chk("resend_stall", stall_cnt, '0);
    end
    set_in('0, '0, 0, 0, '0);
    step_a(); chk("resend_resume", rd_en_sel, 7'b0001000); step_b();

    // Credit starvation on port 0
    do_reset();
    set_in('0, 7'b1111110, 0, 0, '0);
    for (int c = 0; c < INIT; c++) begin step_a(); step_b(); end
    chk("starve_credit0", credit_out[CB-1:0], '0);
    for (int c = 0; c < 5; c++) begin
      step_a(); chk("starve_rd", rd_en_sel, '0); step_b();
    end
    chk("starve_stall5", stall_cnt, 32'd5);
    cret = 7'b0000001;
    step_a(); step_b();
    cret = '0;
    chk("return_credit0", credit_out[CB-1:0], 8'd64);
    chk("return_stall6", stall_cnt, 32'd6);
    step_a(); chk("return_resume", rd_en_sel, 7'b0000001); step_b();

    // Reset mid-operation
    set_in('1, '0, 0, 0, '0);
    reset = 1'b1;
    step_a();
    chk("midrst_fs", fs_ack, '0);
    chk("midrst_rd", rd_en_sel, '0);
    step_b();
    reset = 1'b0;
    chk("midrst_credit", credit_out, {NO{8'd128}});
    chk("midrst_stall", stall_cnt, '0);
    chk("midrst_stream", stream_out, '0);

    // Saturation at the ceiling, including grant+return together
    set_in('0, '1, 0, 0, '1);
    step_a(); step_b();
    chk("sat_full", credit_out, {NO{8'd128}});
    set_in('0, 7'b1111110, 0, 0, 7'b0000001);
    step_a(); chk("sat_grant", rd_en_sel, 7'b0000001); step_b();
    chk("sat_grant_ret", credit_out[CB-1:0], 8'd128);

    // Done mode
    do_reset();
    set_in('0, '0, 0, 1, '0);
    step_a(); chk("done_same_cycle", rd_en_sel, '0); step_b();
    is_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_a(); chk("done_blocked", rd_en_sel, '0); step_b();
    end
    fsu = 7'b0000100;
    step_a(); chk("done_fs_grant", fs_ack, 7'b0000100); step_b();
    fsu = '0;
    do_reset();
    step_a(); chk("done_cleared", rd_en_sel, 7'b0000001); step_b();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      set_pkts(1);
      reset   = ($urandom_range(199) == 0);
      resend  = ($urandom_range(9) == 0);
      is_done = ($urandom_range(499) == 0);
      for (int i = 0; i < NI; i++) fsu[i] = ($urandom_range(9) == 0);
      for (int j = 0; j < NO; j++) begin
        empty[j] = ($urandom_range(3) != 0);
        cret[j]  = ($urandom_range(399) == 0);
      end
      step_a(); step_b();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stream_credit_converge.md
STREAM_CREDIT_CONVERGE -- requirements
Module: stream_credit_converge

Interface
REQ-001 The block SHALL have parameter PACKET_BITS, default 97, packet width; bit PACKET_BITS-1 is the valid bit.
REQ-002 The block SHALL have parameter NUM_IN_PORTS, default 7, number of input-port freespace requesters (1..16).
REQ-003 The block SHALL have parameter NUM_OUT_PORTS, default 7, number of output-port FIFOs (1..16).
REQ-004 The block SHALL have parameter CREDIT_BITS, default 8, width of each per-output-port credit counter.
REQ-005 The block SHALL have parameter INIT_CREDIT, default 128, the credit reset value and saturation ceiling; it SHALL be at most 2^CREDIT_BITS-1.
REQ-006 The block SHALL have parameter CREDIT_RETURN_SIZE, default 64, credits added per credit_return pulse.
REQ-007 The block SHALL have parameter CNT_BITS, default 32, stall counter width.
REQ-008 The block SHALL have the following ports:
- clk  in  1  single clock; one clock only.
- reset  in  1  synchronous, active-high.
- resend  in  1  freeze: no grants; stream_out holds.
- is_done  in  1  enters done mode.
- freespace_update  in  NUM_IN_PORTS  per-input-port request to emit a freespace packet.
- packet_from_input_ports  in  PACKET_BITS*NUM_IN_PORTS  freespace packets; port i at slice i.
- fs_ack  out  NUM_IN_PORTS  one-hot combinational grant to input port.
- empty  in  NUM_OUT_PORTS  output-port FIFO empty flags.
- packet_from_output_ports  in  PACKET_BITS*NUM_OUT_PORTS  FWFT FIFO heads; port j at slice j.
- rd_en_sel  out  NUM_OUT_PORTS  one-hot combinational FIFO pop.
- credit_return  in  NUM_OUT_PORTS  per-port credit-return pulse.
- stream_out  out  PACKET_BITS  registered packet to the network.
- credit_out  out  CREDIT_BITS*NUM_OUT_PORTS  current credit per port.
- stall_cnt  out  CNT_BITS  credit-starvation cycle count.

Function
REQ-009 The block SHALL issue at most one grant per cycle across fs_ack and rd_en_sel combined.
REQ-010 Freespace requests SHALL have strict priority over output-port traffic.
REQ-011 Among asserted freespace_update bits, the block SHALL grant round-robin starting at fs_ptr; after a grant to i, fs_ptr SHALL become (i+1) mod NUM_IN_PORTS.
REQ-012 Output port j SHALL be eligible iff empty[j]=0, its credit>0, and neither done_mode nor is_done is asserted.
REQ-013 With no freespace request, the block SHALL grant the first eligible port at or after out_ptr; after a grant to j, out_ptr SHALL become (j+1) mod NUM_OUT_PORTS.
REQ-014 stream_out SHALL register the granted packet one cycle after the grant (latency 1); with no grant it SHALL load all zeros.
REQ-015 While resend=1: fs_ack=0, rd_en_sel=0, pointers hold, stream_out holds its value, and stall_cnt holds.
REQ-016 While resend=1, credit_return SHALL still be applied.
REQ-017 Credit[j] SHALL decrement by 1 on an rd_en_sel[j] grant.
REQ-018 Credit[j] SHALL increase by CREDIT_RETURN_SIZE on credit_return[j].
REQ-019 A simultaneous grant and return SHALL apply both (net +CREDIT_RETURN_SIZE-1).
REQ-020 The credit result SHALL saturate at INIT_CREDIT, and a credit counter SHALL never underflow.
REQ-021 done_mode SHALL set on the cycle after is_done=1 and clear only on reset.
REQ-022 is_done=1 SHALL block output grants in the same cycle it is asserted.
REQ-023 Freespace grants SHALL continue in done mode.
REQ-024 stall_cnt SHALL increment when all of the following hold: resend=0, no freespace request, not done, at least one port has empty=0, and every such port has credit 0.
REQ-025 stall_cnt SHALL saturate at all ones.
REQ-026 A grant is a combinational function of current inputs and state; the requester SHALL observe fs_ack/rd_en_sel in the same cycle, and the FIFO SHALL pop on rd_en_sel.

Reset
REQ-027 On reset=1 at a clk edge, the block SHALL set stream_out=0, every credit=INIT_CREDIT, fs_ptr=0, out_ptr=0, done_mode=0, stall_cnt=0.
REQ-028 During reset, fs_ack and rd_en_sel SHALL be 0.
REQ-029 Reset mid-transfer SHALL discard the pending grant.

Verification
REQ-030 Priority: freespace_update=0000001, empty=0000000 in the same cycle -> fs_ack[0]=1, rd_en_sel=0; next cycle stream_out=input packet 0.
REQ-031 Round-robin: all output ports non-empty, no requests, 14 cycles -> grant order 0,1,...,6,0,...,6; each credit=126.
REQ-032 Starvation: INIT_CREDIT=2, port 0 only non-empty -> two grants, then rd_en_sel=0 and stall_cnt increments by 1 per cycle; credit_return[0] pulse -> credit=2 (saturated), grants resume next cycle.
REQ-033 Resend: assert resend for 3 cycles with traffic pending -> stream_out constant, no grants, stall_cnt unchanged; an out_ptr of 3 resumes at port 3.
REQ-034 Done: is_done pulse while ports are non-empty -> no output grants from that cycle onward; freespace_update[2]=1 is still granted; reset clears done_mode.
REQ-035 Reset mid-operation: reset asserted with credits at 50 and stall_cnt=9 -> next cycle credits=128, stall_cnt=0, stream_out=0.
